ctech_lib_clk_gate_ctrl_mc: RTL and testbench

- Parametrised multi-channel clock-gate controller; successor to the single-channel enable clock gate.
- One source clock drives NUM_CH glitch-free gated clock outputs.
- Each channel has a per-channel request, a programmable idle hysteresis before gating off, a test/force override, an optional inverted output mode and a per-channel enable status.
- Sits between block-level power management and the clock-tree leaf cells.

---
 rtl/ctech_lib_clk_gate_pkg.sv | 20 ++
 rtl/ctech_lib_clk_gate_cell.sv | 31 +++
 rtl/ctech_lib_clk_gate_ctrl_mc.sv | 124 ++++++++++++
 tb/tb_ctech_lib_clk_gate_ctrl_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ctech_lib_clk_gate_pkg.sv
// Shared types and limits for the multi-channel clock-gate controller.
package ctech_lib_clk_gate_pkg;

  // Per-channel gate state: OFF (gated), ON (running), DRAIN (idle countdown).
  typedef enum logic [1:0] {
    CG_OFF   = 2'd0,
    CG_ON    = 2'd1,
    CG_DRAIN = 2'd2
  } cg_state_t;

  // Widest supported hysteresis field and largest channel count.
  localparam int CG_HYST_W_MAX = 8;
  localparam int CG_CH_MAX     = 32;

  // True when the gate for a channel in state s should be open.
  function automatic logic cg_is_open(input cg_state_t s);
    return (s != CG_OFF);
  endfunction

endpackage

// File: rtl/ctech_lib_clk_gate_cell.sv
// Integrated clock-gate cell: low-transparent enable latch followed by an
// AND (true clock, idles low) or NAND (inverted clock, idles high).
// The latch is cleared by reset so the output drops to its idle level
// immediately, even in the middle of a high phase.
module ctech_lib_clk_gate_cell #(
  parameter int INV_OUT = 0
) (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  output logic clkout
);

  logic en_lat;

  // Capture the enable only while clk is low so no partial pulses escape.
  always_latch begin
    if (!rst_b) begin
      en_lat <= 1'b0;
    end else if (!clk) begin
      en_lat <= en;
    end
  end

  if (INV_OUT != 0) begin : g_inv
    assign clkout = ~(clk & en_lat);
  end else begin : g_true
    assign clkout = clk & en_lat;
  end

endmodule

// File: rtl/ctech_lib_clk_gate_ctrl_mc.sv
// Multi-channel clock-gate controller. Each channel runs an independent
// OFF/ON/DRAIN state machine; DRAIN holds the clock running for a
// programmable number of idle cycles before gating off.
module ctech_lib_clk_gate_ctrl_mc
  import ctech_lib_clk_gate_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int HYST_W   = 4,
  parameter int HYST_DEF = 8,
  parameter int INV_OUT  = 0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NUM_CH-1:0] req,
  input  logic              te,
  input  logic [NUM_CH-1:0] force_on,
  input  logic              hyst_ld,
  input  logic [HYST_W-1:0] hyst_val,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] en_sts,
  output logic [NUM_CH-1:0] chg_pulse
);

  logic [HYST_W-1:0] hyst_q;
  logic [HYST_W-1:0] hyst_d;

  // Hysteresis register: new value only affects later DRAIN loads.
  always_comb begin
    hyst_d = hyst_q;
    if (hyst_ld) begin
      hyst_d = hyst_val;
    end
  end

  // Hysteresis register storage.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hyst_q <= HYST_W'(HYST_DEF);
    end else begin
      hyst_q <= hyst_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    cg_state_t         state_q;
    cg_state_t         state_d;
    logic [HYST_W-1:0] cnt_q;
    logic [HYST_W-1:0] cnt_d;
    logic              en_q;
    logic              en_d;
    logic              chg_q;
    logic              chg_d;
    logic              wake;

    assign wake = req[gi] | force_on[gi] | te;

    // Next state, drain counter and status for this channel.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        CG_OFF: begin
          if (wake) begin
            state_d = CG_ON;
          end
        end
        CG_ON: begin
          if (!wake) begin
            if (hyst_q == '0) begin
              state_d = CG_OFF;
            end else begin
              state_d = CG_DRAIN;
              cnt_d   = hyst_q - 1'b1;
            end
          end
        end
        CG_DRAIN: begin
          // A wake request always beats an expiring count.
          if (wake) begin
            state_d = CG_ON;
          end else if (cnt_q == '0) begin
            state_d = CG_OFF;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = CG_OFF;
        end
      endcase
      en_d  = cg_is_open(state_d);
      chg_d = en_d ^ en_q;
    end

    // Channel state, counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        state_q <= CG_OFF;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        chg_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        en_q    <= en_d;
        chg_q   <= chg_d;
      end
    end

    assign en_sts[gi]    = en_q;
    assign chg_pulse[gi] = chg_q;

    ctech_lib_clk_gate_cell #(
      .INV_OUT (INV_OUT)
    ) u_cell (
      .clk    (clk),
      .rst_b  (rst_b),
      .en     (en_q),
      .clkout (clkout[gi])
    );
  end

endmodule

// File: tb/tb_ctech_lib_clk_gate_ctrl_mc.sv
// Scoreboard bench for the multi-channel clock-gate controller.
// Stimulus runs on the falling edge and queues the expected status for the
// next rising edge; the monitor samples 1ns after each rising edge.
module tb_ctech_lib_clk_gate_ctrl_mc;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [3:0] req;
  logic       te;
  logic [3:0] force_on;
  logic       hyst_ld;
  logic [3:0] hyst_val;
  logic [3:0] clkout;
  logic [3:0] en_sts;
  logic [3:0] chg_pulse;

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  en;
    logic [3:0]  chg;
    logic [3:0]  ck;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned edge_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  ctech_lib_clk_gate_ctrl_mc #(
    .NUM_CH   (4),
    .HYST_W   (4),
    .HYST_DEF (8),
    .INV_OUT  (0)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       (req),
    .te        (te),
    .force_on  (force_on),
    .hyst_ld   (hyst_ld),
    .hyst_val  (hyst_val),
    .clkout    (clkout),
    .en_sts    (en_sts),
    .chg_pulse (chg_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, required %b", name, edge_cnt, act, exp_v);
    end
  endtask

  function automatic void push(input logic [3:0] en, input logic [3:0] chg, input logic [3:0] ck);
    exp_t e;
    e.edge_n = edge_cnt + 1;
    e.en     = en;
    e.chg    = chg;
    e.ck     = ck;
    exp_q.push_back(e);
  endfunction

  // Monitor: compare queued expectations against the DUT after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() != 0 && exp_q[0].edge_n <= edge_cnt) begin
        e = exp_q.pop_front();
        if (e.edge_n != edge_cnt) begin
          n_chk++;
          n_fail++;
          $display("FAIL stale_expect: expected edge %0d, now at edge %0d", e.edge_n, edge_cnt);
        end else begin
          $display("edge %0d: en_sts=%b chg_pulse=%b clkout=%b (exp %b %b %b)",
                   edge_cnt, en_sts, chg_pulse, clkout, e.en, e.chg, e.ck);
          check4("en_sts", en_sts, e.en);
          check4("chg_pulse", chg_pulse, e.chg);
          check4("clkout_high", clkout, e.ck);
        end
      end
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b    = 1'b0;
    req      = 4'hF;
    te       = 1'b0;
    force_on = 4'h0;
    hyst_ld  = 1'b0;
    hyst_val = 4'h0;

    // Reset with every request high: everything idle.
    repeat (3) begin
      @(negedge clk);
      push(4'h0, 4'h0, 4'h0);
    end
    @(negedge clk);
    rst_b = 1'b1;
    push(4'hF, 4'hF, 4'h0);
    @(negedge clk);
    push(4'hF, 4'h0, 4'hF);

    // Ch0 drains 8 cycles and gates off; ch1 re-wakes mid-drain.
    for (int r = 1; r <= 11; r++) begin
      @(negedge clk);
      if (r == 1) req = 4'b1100;
      if (r == 5) req[1] = 1'b1;
      push({3'b111, 1'(r <= 8)}, {3'b000, 1'(r == 9)}, {3'b111, 1'(r <= 9)});
    end

    // hyst_ld=0 coincides with ch3 entering DRAIN (keeps old 8); ch2 then
    // gates off one edge after its last request.
    for (int r = 1; r <= 11; r++) begin
      @(negedge clk);
      if (r == 1) begin
        req      = 4'b0110;
        hyst_ld  = 1'b1;
        hyst_val = 4'd0;
      end
      if (r == 2) hyst_ld = 1'b0;
      if (r == 3) req = 4'b0010;
      push({1'(r <= 8), 1'(r <= 2), 2'b10},
           {1'(r == 9), 1'(r == 3), 2'b00},
           {1'(r <= 9), 1'(r <= 3), 2'b10});
    end

    // Restore hysteresis 8 (ch1 drops with old value 0), then te override.
    for (int r = 1; r <= 14; r++) begin
      @(negedge clk);
      if (r == 1) begin
        req      = 4'b0000;
        hyst_ld  = 1'b1;
        hyst_val = 4'd8;
      end
      if (r == 2) hyst_ld = 1'b0;
      if (r == 3) te = 1'b1;
      if (r == 5) te = 1'b0;
      if (r == 1)       push(4'h0, 4'b0010, 4'b0010);
      else if (r == 2)  push(4'h0, 4'h0, 4'h0);
      else if (r == 3)  push(4'hF, 4'hF, 4'h0);
      else if (r <= 12) push(4'hF, 4'h0, 4'hF);
      else if (r == 13) push(4'h0, 4'hF, 4'hF);
      else              push(4'h0, 4'h0, 4'h0);
    end

    // Ch0 into DRAIN, then asynchronous reset during a high phase.
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      if (r == 1) req = 4'b0001;
      if (r == 2) req = 4'b0000;
      if (r == 1) push(4'b0001, 4'b0001, 4'b0000);
      else        push(4'b0001, 4'b0000, 4'b0001);
    end
    @(posedge clk);
    #2;
    check4("clkout_pre_reset", clkout, 4'b0001);
    rst_b = 1'b0;
    #1;
    check4("clkout_async_reset", clkout, 4'b0000);
    check4("en_sts_async_reset", en_sts, 4'b0000);
    check4("chg_async_reset", chg_pulse, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    req   = 4'b0010;
    push(4'b0010, 4'b0010, 4'b0000);
    @(negedge clk);
    push(4'b0010, 4'b0000, 4'b0010);

    // Ch1 re-wakes on the very edge its drain count hits zero.
    for (int r = 1; r <= 11; r++) begin
      @(negedge clk);
      if (r == 1) req = 4'b0000;
      if (r == 9) req = 4'b0010;
      push(4'b0010, 4'b0000, 4'b0010);
    end

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
